// File: rtl/bcd_clock_core.sv
// BCD hh:mm:ss time-of-day core with tick prescaler, 24/12-hour modes,
// button-driven time/alarm setting FSM and a timed alarm output.
//
// state  | meaning
// RUN    | normal timekeeping, time displayed
// SET_H  | time frozen, inc_btn edits hours
// SET_M  | time frozen, inc_btn edits minutes; leaving zeroes seconds and prescaler
// SET_AH | time runs, alarm displayed, inc_btn edits alarm hours
// SET_AM | time runs, alarm displayed, inc_btn edits alarm minutes
module bcd_clock_core #(
  parameter int CLK_DIV   = 100_000_000,
  parameter bit TWELVE_HR = 1'b0,
  parameter int ALARM_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        alarm_off,
  output logic [23:0] hexs,
  output logic        pm,
  output logic [5:0]  les,
  output logic        sec_tick,
  output logic        alarm
);

  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_AH, SET_AM} state_t;

  localparam int            PW    = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HALF  = PW'(CLK_DIV / 2);
  localparam logic [7:0]    H_RST = TWELVE_HR ? 8'h12 : 8'h00;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [7:0]    hr_q, mn_q, sc_q, ahr_q, amn_q, acnt_q;
  logic          pm_q, apm_q, alarm_q;
  logic [7:0]    n_hr, n_mn, n_sc;
  logic          n_pm, counting, do_inc, match, leave_set_m, show_alarm, blink;

  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v == 8'h59)      return 8'h00;
    if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {pm, hour}; 12-hour mode flips pm on the 11 -> 12 step.
  function automatic logic [8:0] inc_hour(input logic [7:0] h, input logic p);
    if (TWELVE_HR) begin
      if (h == 8'h11) return {~p, 8'h12};
      if (h == 8'h12) return {p, 8'h01};
    end else if (h == 8'h23) begin
      return {p, 8'h00};
    end
    if (h[3:0] == 4'd9) return {p, h[7:4] + 4'd1, 4'd0};
    return {p, h[7:4], h[3:0] + 4'd1};
  endfunction

  assign sec_tick    = en && (pre_q == LAST);
  assign counting    = (state_q == RUN) || (state_q == SET_AH) || (state_q == SET_AM);
  assign do_inc      = inc_btn && !mode_btn;
  assign leave_set_m = (state_q == SET_M) && mode_btn;
  assign show_alarm  = (state_q == SET_AH) || (state_q == SET_AM);
  assign blink       = (pre_q >= HALF);

  always_comb begin
    n_sc = inc60(sc_q);
    n_mn = mn_q;
    n_hr = hr_q;
    n_pm = pm_q;
    if (sc_q == 8'h59) begin
      n_mn = inc60(mn_q);
      if (mn_q == 8'h59) {n_pm, n_hr} = inc_hour(hr_q, pm_q);
    end
  end

  assign match = (n_hr == ahr_q) && (n_mn == amn_q) && (n_sc == 8'h00) &&
                 (!TWELVE_HR || (n_pm == apm_q));

  always_comb begin
    state_d = state_q;
    if (mode_btn) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_AH;
        SET_AH:  state_d = SET_AM;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pre_q   <= '0;
      hr_q    <= H_RST;
      mn_q    <= 8'h00;
      sc_q    <= 8'h00;
      pm_q    <= 1'b0;
      ahr_q   <= H_RST;
      amn_q   <= 8'h00;
      apm_q   <= 1'b0;
      alarm_q <= 1'b0;
      acnt_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (leave_set_m)   pre_q <= '0;
      else if (en)       pre_q <= (pre_q == LAST) ? '0 : pre_q + PW'(1);

      if (sec_tick && counting) begin
        sc_q <= n_sc;
        mn_q <= n_mn;
        hr_q <= n_hr;
        pm_q <= n_pm;
      end
      if (leave_set_m) sc_q <= 8'h00;

      if (do_inc) begin
        case (state_q)
          SET_H:   {pm_q, hr_q}   <= inc_hour(hr_q, pm_q);
          SET_M:   mn_q           <= inc60(mn_q);
          SET_AH:  {apm_q, ahr_q} <= inc_hour(ahr_q, apm_q);
          SET_AM:  amn_q          <= inc60(amn_q);
          default: ;
        endcase
      end

      // Acknowledge beats a simultaneous re-match.
      if (alarm_off) begin
        alarm_q <= 1'b0;
      end else if (sec_tick && counting && match) begin
        alarm_q <= 1'b1;
        acnt_q  <= 8'(ALARM_LEN);
      end else if (alarm_q && sec_tick) begin
        if (acnt_q == 8'd1) alarm_q <= 1'b0;
        acnt_q <= acnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    les = 6'b111111;
    if (blink) begin
      if (state_q == SET_H || state_q == SET_AH) les[5:4] = 2'b00;
      if (state_q == SET_M || state_q == SET_AM) les[3:2] = 2'b00;
    end
  end

  assign hexs  = show_alarm ? {ahr_q, amn_q, 8'h00} : {hr_q, mn_q, sc_q};
  assign pm    = TWELVE_HR ? (show_alarm ? apm_q : pm_q) : 1'b0;
  assign alarm = alarm_q;

endmodule
